// File: rtl/spi_host_stream_window.sv
// Regbus-to-stream window pair for the SPI host datapath.
// A TX window write lands in a Depth-entry staging FIFO that feeds the TX stream.
// An RX window read pops the RX stream with zero latency.
// StallMode selects how a full TX FIFO or an empty RX stream is handled:
//   StallMode=1: the bus is held off (ready=0). RX reads give up after RxTimeout cycles.
//   StallMode=0: the window responds at once with error=1.
// Ports:
//   clk_i, rst_ni           clock, asynchronous active-low reset
//   tx_win_i / tx_win_o     TX window regbus request / response (response is combinational)
//   rx_win_i / rx_win_o     RX window regbus request / response (response is combinational)
//   tx_data_o, tx_be_o      TX stream head data / byte enables
//   tx_valid_o, tx_ready_i  TX stream handshake
//   rx_data_i, rx_valid_i   RX stream data / valid
//   rx_ready_o              RX stream pop (combinational, only with a completing RX read)
//   flush_i                 synchronous clear of the TX FIFO and the RX timeout
//   tx_depth_o              registered TX FIFO occupancy
//   overflow_o, underflow_o one-cycle pulses for a dropped TX write / an errored RX read

package spi_host_stream_window_pkg;

    localparam int unsigned RegAw = 32;
    localparam int unsigned RegDw = 32;

    typedef struct packed {
        logic               valid;
        logic               write;
        logic [RegAw-1:0]   addr;
        logic [RegDw-1:0]   wdata;
        logic [RegDw/8-1:0] wstrb;
    } reg_req_t;

    typedef struct packed {
        logic [RegDw-1:0] rdata;
        logic             error;
        logic             ready;
    } reg_rsp_t;

endpackage

module spi_host_stream_window #(
    parameter type         reg_req_t = spi_host_stream_window_pkg::reg_req_t,
    parameter type         reg_rsp_t = spi_host_stream_window_pkg::reg_rsp_t,
    parameter int unsigned DW        = 32,
    parameter int unsigned Depth     = 4,
    parameter bit          StallMode = 1'b1,
    parameter int unsigned RxTimeout = 64
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  reg_req_t                   tx_win_i,
    output reg_rsp_t                   tx_win_o,
    input  reg_req_t                   rx_win_i,
    output reg_rsp_t                   rx_win_o,
    output logic [DW-1:0]              tx_data_o,
    output logic [DW/8-1:0]            tx_be_o,
    output logic                       tx_valid_o,
    input  logic                       tx_ready_i,
    input  logic [DW-1:0]              rx_data_i,
    input  logic                       rx_valid_i,
    output logic                       rx_ready_o,
    input  logic                       flush_i,
    output logic [$clog2(Depth+1)-1:0] tx_depth_o,
    output logic                       overflow_o,
    output logic                       underflow_o
);

    localparam int unsigned BW   = DW / 8;
    localparam int unsigned CntW = $clog2(Depth + 1);
    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned TmW  = $clog2(RxTimeout + 1);

    // Elaboration-time parameter sanity check
    if ((DW % 8 != 0) || (DW != $bits(tx_win_i.wdata))) begin : g_bad_dw
        $error("spi_host_stream_window: DW must be a multiple of 8 and match the wdata width");
    end

    logic [DW-1:0]   mem_data [Depth];
    logic [BW-1:0]   mem_be   [Depth];
    logic [PtrW-1:0] wr_ptr;
    logic [PtrW-1:0] rd_ptr;
    logic [CntW-1:0] count;
    logic [TmW-1:0]  rx_timer;
    logic            overflow_q;
    logic            underflow_q;

    logic tx_full_c;
    logic push_c;
    logic pop_c;
    logic overflow_c;
    logic underflow_c;
    logic rx_stall_c;

    // The window address is decoded upstream; RX write payloads are discarded
    logic unused_fields;
    assign unused_fields = ^{tx_win_i.addr, rx_win_i.addr, rx_win_i.wdata, rx_win_i.wstrb};

    // Full is judged on the registered count, so a same-cycle pop frees no space
    assign tx_full_c  = (count == CntW'(Depth));
    assign tx_valid_o = (count != '0);
    assign tx_data_o  = mem_data[rd_ptr];
    assign tx_be_o    = mem_be[rd_ptr];
    assign tx_depth_o = count;
    assign overflow_o  = overflow_q;
    assign underflow_o = underflow_q;

    // A flush takes priority over a pop
    assign pop_c = tx_valid_o & tx_ready_i & ~flush_i;

    // TX window response and push decision
    always_comb begin
        tx_win_o   = '0;
        push_c     = 1'b0;
        overflow_c = 1'b0;
        if (tx_win_i.valid) begin
            if (!tx_win_i.write) begin
                tx_win_o.ready = 1'b1;
                tx_win_o.error = 1'b1;
            end else if (tx_win_i.wstrb == '0) begin
                tx_win_o.ready = 1'b1;
            end else if (tx_full_c) begin
                // A stalled write keeps waiting through a flush and lands afterwards
                if (!StallMode) begin
                    tx_win_o.ready = 1'b1;
                    if (!flush_i) begin
                        tx_win_o.error = 1'b1;
                        overflow_c     = 1'b1;
                    end
                end
            end else begin
                // A write in a flush cycle is acknowledged but discarded
                tx_win_o.ready = 1'b1;
                push_c         = ~flush_i;
            end
        end
    end

    // RX window response, stream pop and timeout decision
    always_comb begin
        rx_win_o    = '0;
        rx_ready_o  = 1'b0;
        underflow_c = 1'b0;
        rx_stall_c  = 1'b0;
        if (rx_win_i.valid) begin
            if (rx_win_i.write) begin
                rx_win_o.ready = 1'b1;
                rx_win_o.error = 1'b1;
            end else if (rx_valid_i) begin
                rx_win_o.ready = 1'b1;
                rx_win_o.rdata = rx_data_i;
                rx_ready_o     = 1'b1;
            end else if (!StallMode || (rx_timer == TmW'(RxTimeout - 1))) begin
                rx_win_o.ready = 1'b1;
                rx_win_o.error = 1'b1;
                underflow_c    = 1'b1;
            end else begin
                rx_stall_c = 1'b1;
            end
        end
    end

    // FIFO storage, pointers, occupancy, pulses and RX timeout counter
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < Depth; i++) begin
                mem_data[i] <= '0;
                mem_be[i]   <= '0;
            end
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            rx_timer    <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_c;
            underflow_q <= underflow_c;
            rx_timer    <= (flush_i || !rx_stall_c) ? '0 : rx_timer + TmW'(1);
            if (flush_i) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push_c) begin
                    mem_data[wr_ptr] <= tx_win_i.wdata;
                    mem_be[wr_ptr]   <= tx_win_i.wstrb;
                    wr_ptr <= (wr_ptr == PtrW'(Depth - 1)) ? '0 : wr_ptr + PtrW'(1);
                end
                if (pop_c) begin
                    rd_ptr <= (rd_ptr == PtrW'(Depth - 1)) ? '0 : rd_ptr + PtrW'(1);
                end
                case ({push_c, pop_c})
                    2'b10:   count <= count + CntW'(1);
                    2'b01:   count <= count - CntW'(1);
                    default: count <= count;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_host_stream_window.sv
// Directed bench for spi_host_stream_window.
// u_stall: Depth=4, StallMode=1, RxTimeout=8. u_err: Depth=4, StallMode=0.
// Inputs change 1 time unit after a rising edge. Combinational responses are
// checked 1 unit after that, and registered outputs right after the edge.
module tb_spi_host_stream_window;
    import spi_host_stream_window_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    reg_req_t    s_tx_req, s_rx_req, e_tx_req, e_rx_req;
    reg_rsp_t    s_tx_rsp, s_rx_rsp, e_tx_rsp, e_rx_rsp;
    logic [31:0] s_tx_data, e_tx_data, s_rx_data, e_rx_data;
    logic [3:0]  s_tx_be, e_tx_be;
    logic        s_tx_valid, e_tx_valid, s_tx_ready, e_tx_ready;
    logic        s_rx_valid, e_rx_valid, s_rx_ready, e_rx_ready;
    logic        s_flush, e_flush;
    logic [2:0]  s_depth, e_depth;
    logic        s_overflow, e_overflow, s_underflow, e_underflow;

    spi_host_stream_window #(.DW(32), .Depth(4), .StallMode(1'b1), .RxTimeout(8)) u_stall (
        .clk_i(clk), .rst_ni(rst_n),
        .tx_win_i(s_tx_req), .tx_win_o(s_tx_rsp), .rx_win_i(s_rx_req), .rx_win_o(s_rx_rsp),
        .tx_data_o(s_tx_data), .tx_be_o(s_tx_be), .tx_valid_o(s_tx_valid), .tx_ready_i(s_tx_ready),
        .rx_data_i(s_rx_data), .rx_valid_i(s_rx_valid), .rx_ready_o(s_rx_ready),
        .flush_i(s_flush), .tx_depth_o(s_depth), .overflow_o(s_overflow), .underflow_o(s_underflow)
    );

    spi_host_stream_window #(.DW(32), .Depth(4), .StallMode(1'b0), .RxTimeout(8)) u_err (
        .clk_i(clk), .rst_ni(rst_n),
        .tx_win_i(e_tx_req), .tx_win_o(e_tx_rsp), .rx_win_i(e_rx_req), .rx_win_o(e_rx_rsp),
        .tx_data_o(e_tx_data), .tx_be_o(e_tx_be), .tx_valid_o(e_tx_valid), .tx_ready_i(e_tx_ready),
        .rx_data_i(e_rx_data), .rx_valid_i(e_rx_valid), .rx_ready_o(e_rx_ready),
        .flush_i(e_flush), .tx_depth_o(e_depth), .overflow_o(e_overflow), .underflow_o(e_underflow)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic reg_req_t wr_req(input logic [31:0] d, input logic [3:0] be);
        reg_req_t r;
        r = '{valid: 1'b1, write: 1'b1, addr: 32'h0, wdata: d, wstrb: be};
        return r;
    endfunction

    function automatic reg_req_t rd_req();
        reg_req_t r;
        r = '{valid: 1'b1, write: 1'b0, addr: 32'h0, wdata: 32'h0, wstrb: 4'h0};
        return r;
    endfunction

    // One acknowledged TX write on the chosen instance (0: u_stall, 1: u_err)
    task automatic tx_write(input bit inst, input logic [31:0] d, input logic [3:0] be,
                            input logic exp_err, input string tag);
        reg_rsp_t rsp;
        if (inst) e_tx_req = wr_req(d, be);
        else      s_tx_req = wr_req(d, be);
        #1;
        rsp = inst ? e_tx_rsp : s_tx_rsp;
        check({tag, "_ready"}, 32'(rsp.ready), 32'd1);
        check({tag, "_error"}, 32'(rsp.error), 32'(exp_err));
        step();
        if (inst) e_tx_req = '0;
        else      s_tx_req = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_q [4];
        rst_n = 1'b0;
        s_tx_req = '0; s_rx_req = '0; e_tx_req = '0; e_rx_req = '0;
        s_tx_ready = 1'b0; e_tx_ready = 1'b0; s_rx_valid = 1'b0; e_rx_valid = 1'b0;
        s_rx_data = '0; e_rx_data = '0; s_flush = 1'b0; e_flush = 1'b0;
        #3;
        check("rst_tx_valid", 32'(s_tx_valid), 32'd0);
        check("rst_depth", 32'(s_depth), 32'd0);
        check("rst_overflow", 32'(s_overflow), 32'd0);
        check("rst_underflow", 32'(s_underflow), 32'd0);
        check("rst_rx_ready", 32'(s_rx_ready), 32'd0);
        check("rst_tx_rsp_ready", 32'(s_tx_rsp.ready), 32'd0);
        check("rst_rx_rsp_ready", 32'(s_rx_rsp.ready), 32'd0);
        step(); step();
        rst_n = 1'b1;
        step();

        // Fill the stalling FIFO, then a fifth write stalls until a pop
        tx_write(1'b0, 32'h11111111, 4'hF, 1'b0, "fill1");
        tx_write(1'b0, 32'h22222222, 4'hF, 1'b0, "fill2");
        tx_write(1'b0, 32'h33333333, 4'hF, 1'b0, "fill3");
        tx_write(1'b0, 32'h44444444, 4'hF, 1'b0, "fill4");
        check("full_depth", 32'(s_depth), 32'd4);
        check("full_head", s_tx_data, 32'h11111111);
        s_tx_req = wr_req(32'h55555555, 4'hF);
        #1;
        check("stall_ready_c1", 32'(s_tx_rsp.ready), 32'd0);
        step();
        check("stall_ready_c2", 32'(s_tx_rsp.ready), 32'd0);
        s_tx_ready = 1'b1;
        #1;
        check("stall_same_cycle_pop", 32'(s_tx_rsp.ready), 32'd0);
        check("pop_head", s_tx_data, 32'h11111111);
        step();
        s_tx_ready = 1'b0;
        #1;
        check("after_pop_depth", 32'(s_depth), 32'd3);
        check("stall_release_ready", 32'(s_tx_rsp.ready), 32'd1);
        check("stall_release_error", 32'(s_tx_rsp.error), 32'd0);
        step();
        s_tx_req = '0;
        check("refill_depth", 32'(s_depth), 32'd4);
        exp_q = '{32'h22222222, 32'h33333333, 32'h44444444, 32'h55555555};
        s_tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("drain_order%0d", i), s_tx_data, exp_q[i]);
            step();
        end
        s_tx_ready = 1'b0;
        check("drained_valid", 32'(s_tx_valid), 32'd0);
        check("drained_depth", 32'(s_depth), 32'd0);

        // Byte strobes: empty strobe is acked without a push, partial strobe reaches the head
        tx_write(1'b0, 32'h99999999, 4'h0, 1'b0, "zero_strb");
        check("zero_strb_depth", 32'(s_depth), 32'd0);
        tx_write(1'b0, 32'hAABBCCDD, 4'b0101, 1'b0, "part_strb");
        check("part_strb_be", 32'(s_tx_be), 32'h5);
        check("part_strb_data", s_tx_data, 32'hAABBCCDD);
        check("part_strb_depth", 32'(s_depth), 32'd1);
        s_tx_ready = 1'b1;
        step();
        s_tx_ready = 1'b0;
        check("part_strb_popped", 32'(s_depth), 32'd0);

        // Flush with 3 queued entries plus a concurrent write
        tx_write(1'b0, 32'h01010101, 4'hF, 1'b0, "pre_flush1");
        tx_write(1'b0, 32'h02020202, 4'hF, 1'b0, "pre_flush2");
        tx_write(1'b0, 32'h03030303, 4'hF, 1'b0, "pre_flush3");
        check("pre_flush_depth", 32'(s_depth), 32'd3);
        s_flush = 1'b1;
        s_tx_req = wr_req(32'h77777777, 4'hF);
        #1;
        check("flush_wr_ready", 32'(s_tx_rsp.ready), 32'd1);
        check("flush_wr_error", 32'(s_tx_rsp.error), 32'd0);
        step();
        s_flush = 1'b0;
        s_tx_req = '0;
        check("flush_depth", 32'(s_depth), 32'd0);
        check("flush_valid", 32'(s_tx_valid), 32'd0);
        check("flush_overflow", 32'(s_overflow), 32'd0);
        s_tx_req = rd_req();
        #1;
        check("tx_read_ready", 32'(s_tx_rsp.ready), 32'd1);
        check("tx_read_error", 32'(s_tx_rsp.error), 32'd1);
        check("tx_read_rdata", s_tx_rsp.rdata, 32'h0);
        step();
        s_tx_req = '0;
        check("tx_read_depth", 32'(s_depth), 32'd0);

        // A write stalled on a full FIFO lands after a flush clears it
        tx_write(1'b0, 32'hA0000001, 4'hF, 1'b0, "sf1");
        tx_write(1'b0, 32'hA0000002, 4'hF, 1'b0, "sf2");
        tx_write(1'b0, 32'hA0000003, 4'hF, 1'b0, "sf3");
        tx_write(1'b0, 32'hA0000004, 4'hF, 1'b0, "sf4");
        s_tx_req = wr_req(32'h66666666, 4'hF);
        s_flush = 1'b1;
        #1;
        check("stall_flush_ready", 32'(s_tx_rsp.ready), 32'd0);
        step();
        s_flush = 1'b0;
        #1;
        check("stall_after_flush_ready", 32'(s_tx_rsp.ready), 32'd1);
        check("stall_after_flush_depth", 32'(s_depth), 32'd0);
        step();
        s_tx_req = '0;
        check("stall_landed_depth", 32'(s_depth), 32'd1);
        check("stall_landed_data", s_tx_data, 32'h66666666);
        s_flush = 1'b1;
        step();
        s_flush = 1'b0;

        // Zero-latency RX read
        s_rx_valid = 1'b1;
        s_rx_data = 32'hCAFEF00D;
        s_rx_req = rd_req();
        #1;
        check("rx_hit_ready", 32'(s_rx_rsp.ready), 32'd1);
        check("rx_hit_rdata", s_rx_rsp.rdata, 32'hCAFEF00D);
        check("rx_hit_pop", 32'(s_rx_ready), 32'd1);
        check("rx_hit_error", 32'(s_rx_rsp.error), 32'd0);
        step();
        s_rx_req = wr_req(32'h12121212, 4'hF);
        #1;
        check("rx_write_ready", 32'(s_rx_rsp.ready), 32'd1);
        check("rx_write_error", 32'(s_rx_rsp.error), 32'd1);
        check("rx_write_no_pop", 32'(s_rx_ready), 32'd0);
        step();
        s_rx_req = '0;
        s_rx_valid = 1'b0;

        // RX timeout: 7 stalled cycles, error on the 8th
        s_rx_req = rd_req();
        for (int c = 1; c <= 7; c++) begin
            #1;
            check($sformatf("rx_stall_c%0d", c), 32'(s_rx_rsp.ready), 32'd0);
            check($sformatf("rx_stall_pop_c%0d", c), 32'(s_rx_ready), 32'd0);
            step();
        end
        #1;
        check("rx_timeout_ready", 32'(s_rx_rsp.ready), 32'd1);
        check("rx_timeout_error", 32'(s_rx_rsp.error), 32'd1);
        check("rx_timeout_rdata", s_rx_rsp.rdata, 32'h0);
        check("rx_timeout_no_pulse_yet", 32'(s_underflow), 32'd0);
        step();
        s_rx_req = '0;
        check("rx_underflow_pulse", 32'(s_underflow), 32'd1);
        step();
        check("rx_underflow_clear", 32'(s_underflow), 32'd0);

        // RX data arriving in the third stalled cycle completes cleanly
        s_rx_req = rd_req();
        for (int c = 1; c <= 2; c++) begin
            #1;
            check($sformatf("rx_late_stall_c%0d", c), 32'(s_rx_rsp.ready), 32'd0);
            step();
        end
        s_rx_valid = 1'b1;
        s_rx_data = 32'h12345678;
        #1;
        check("rx_late_ready", 32'(s_rx_rsp.ready), 32'd1);
        check("rx_late_error", 32'(s_rx_rsp.error), 32'd0);
        check("rx_late_rdata", s_rx_rsp.rdata, 32'h12345678);
        check("rx_late_pop", 32'(s_rx_ready), 32'd1);
        step();
        s_rx_req = '0;
        s_rx_valid = 1'b0;
        check("rx_late_no_underflow", 32'(s_underflow), 32'd0);

        // Error mode: overflow on a full FIFO, dropped data never appears
        tx_write(1'b1, 32'h11111111, 4'hF, 1'b0, "e_fill1");
        tx_write(1'b1, 32'h22222222, 4'hF, 1'b0, "e_fill2");
        tx_write(1'b1, 32'h33333333, 4'hF, 1'b0, "e_fill3");
        tx_write(1'b1, 32'h44444444, 4'hF, 1'b0, "e_fill4");
        check("e_no_overflow_yet", 32'(e_overflow), 32'd0);
        tx_write(1'b1, 32'hDEADBEEF, 4'hF, 1'b1, "e_overflow_wr");
        check("e_overflow_pulse", 32'(e_overflow), 32'd1);
        check("e_overflow_depth", 32'(e_depth), 32'd4);
        step();
        check("e_overflow_clear", 32'(e_overflow), 32'd0);
        exp_q = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
        e_tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("e_drain%0d", i), e_tx_data, exp_q[i]);
            step();
        end
        e_tx_ready = 1'b0;
        check("e_drained_valid", 32'(e_tx_valid), 32'd0);

        // Error mode: empty RX stream errors at once
        e_rx_req = rd_req();
        #1;
        check("e_rx_ready", 32'(e_rx_rsp.ready), 32'd1);
        check("e_rx_error", 32'(e_rx_rsp.error), 32'd1);
        check("e_rx_rdata", e_rx_rsp.rdata, 32'h0);
        check("e_rx_no_pop", 32'(e_rx_ready), 32'd0);
        step();
        e_rx_req = '0;
        check("e_underflow_pulse", 32'(e_underflow), 32'd1);
        step();
        check("e_underflow_clear", 32'(e_underflow), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_host_stream_window.md
Name: spi_host_stream_window

Overview:
- Parametrised regbus-to-stream window pair for the SPI host datapath.
- TX window: CPU writes go into a Depth-entry staging FIFO that drives a valid/ready TX stream toward the SPI shift engine.
- RX window: CPU reads pop a valid/ready RX stream.
- Full and empty conditions are handled either by bus back-pressure, bounded by a timeout, or by immediate error, selected by parameter. Sits between the SPI host register file demux and the TX/RX data FIFOs.

Parameters:
- reg_req_t, logic, regbus request struct (valid, write, addr, wdata, wstrb).
- reg_rsp_t, logic, regbus response struct (rdata, error, ready).
- DW, 32, window/stream data width; must be a multiple of 8 and equal $bits(wdata) (init assertion).
- Depth, 4, TX staging FIFO entries, ≥1, any integer.
- StallMode, 1, 1: back-pressure bus on full/empty; 0: respond immediately with error.
- RxTimeout, 64, cycles a stalled RX read may wait before erroring (StallMode=1 only), ≥1.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- tx_win_i  in  reg_req_t  TX window request
- tx_win_o  out  reg_rsp_t  TX window response
- rx_win_i  in  reg_req_t  RX window request
- rx_win_o  out  reg_rsp_t  RX window response
- tx_data_o  out  DW  TX stream data (FIFO head)
- tx_be_o  out  DW/8  TX stream byte enables (FIFO head)
- tx_valid_o  out  1  TX stream valid
- tx_ready_i  in  1  TX stream ready
- rx_data_i  in  DW  RX stream data
- rx_valid_i  in  1  RX stream valid
- rx_ready_o  out  1  RX stream pop
- flush_i  in  1  synchronous clear of TX FIFO and RX timeout
- tx_depth_o  out  $clog2(Depth+1)  current TX FIFO occupancy
- overflow_o  out  1  one-cycle pulse: TX write dropped
- underflow_o  out  1  one-cycle pulse: RX read errored

Behaviour:
- Reset (async, rst_ni=0): FIFO pointers and count 0, tx_valid_o=0, tx_depth_o=0, overflow_o=0, underflow_o=0, RX timeout counter 0. rx_ready_o and window responses are combinational; all 0 when no request is pending. Reset mid-stall drops the stalled request state.
- Regbus rule: master holds valid and fields until ready=1. Transfer completes in the ready=1 cycle. rdata and error are valid only then.
- TX write (valid & write):
  - FIFO not full: ready=1, error=0, {wdata,wstrb} pushed.
  - wstrb==0: ready=1, no push.
  - Full is judged on the registered count, so a same-cycle pop does not free space for that write.
  - Full, StallMode=1: ready=0 until the count drops.
  - Full, StallMode=0: ready=1, error=1, data dropped, overflow_o pulses the next cycle.
- TX read (valid & ~write): ready=1, error=1, rdata=0, no state change.
- TX stream: tx_valid_o = count≠0; head is presented registered. A push at cycle N is visible at N+1. Pop occurs on tx_valid_o & tx_ready_i. Simultaneous push and pop with count not full leaves count unchanged. Pointers wrap Depth-1→0.
- RX read (valid & ~write):
  - rx_valid_i=1: ready=1, error=0, rdata=rx_data_i, rx_ready_o=1 in the same cycle (zero latency).
  - rx_valid_i=0, StallMode=0: ready=1, error=1, rdata=0, underflow_o pulses next cycle.
  - rx_valid_i=0, StallMode=1: ready=0 and the timeout counter increments each stalled cycle. When the count reaches RxTimeout-1: ready=1, error=1, rdata=0, underflow pulse. The counter clears on any completed RX transfer or when there is no request.
- RX write: ready=1, error=1, rx_ready_o=0.
- rx_ready_o is never 1 without a completing RX read.
- flush_i:
  - Next cycle: count=0, pointers=0, tx_valid_o=0, RX timeout=0.
  - A TX write in the flush cycle is acknowledged (ready=1, error=0) and discarded.
  - A stalled TX write completes once space exists after the flush.
  - No overflow/underflow pulse is caused by flush.
- tx_depth_o is registered and equals the occupancy after the previous edge.

Test Plan:
- Depth=4, StallMode=1: 4 back-to-back writes 0x11111111..0x44444444 with tx_ready_i=0 → all acked, tx_depth_o=4. A 5th write 0x55555555 stalls with ready=0. Raise tx_ready_i for 1 cycle → 0x11111111 popped, 5th write acked the following cycle, stream order 0x22222222,0x33333333,0x44444444,0x55555555.
- StallMode=0, FIFO full, write 0xDEADBEEF → ready=1, error=1, overflow_o=1 one cycle later, tx_depth_o stays 4, 0xDEADBEEF never on tx_data_o.
- RX read with rx_valid_i=1, rx_data_i=0xCAFEF00D → same-cycle ready=1, rdata=0xCAFEF00D, rx_ready_o=1, error=0.
- StallMode=1, RxTimeout=8, RX read with rx_valid_i=0 → ready=0 for 7 cycles, ready=1 and error=1 on the 8th, underflow_o pulses. Repeat with rx_valid_i rising at cycle 3 → completes at cycle 3, no error.
- Write wstrb=4'b0000 → acked, tx_depth_o unchanged. Write wstrb=4'b0101 data 0xAABBCCDD → tx_be_o=4'b0101 at head.
- 3 entries queued, flush_i together with a new write → next cycle tx_depth_o=0, tx_valid_o=0, write acked with error=0, no overflow_o. TX window read → error=1, rdata=0.
